// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the APB UART controller: register offsets, bit indices, FSM and access encodings.
package uart_ctrl_pkg;

    localparam logic [4:0] OFF_CTRL = 5'h00;
    localparam logic [4:0] OFF_BAUD = 5'h04;
    localparam logic [4:0] OFF_TX   = 5'h08;
    localparam logic [4:0] OFF_RX   = 5'h0C;
    localparam logic [4:0] OFF_STAT = 5'h10;

    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_IRQ_EN = 1;
    localparam int CTRL_TX_IRQ_EN = 2;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_RX_EMPTY = 1;
    localparam int ST_TX_OVF   = 2;
    localparam int ST_RX_UDF   = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_POP     = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    // What the pending transfer will do when it completes, decided in the setup phase.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_WR_CTRL,
        ACT_WR_BAUD,
        ACT_WR_STAT,
        ACT_TX_PUSH,
        ACT_TX_OVF,
        ACT_RX_UDF,
        ACT_RX_POP
    } act_t;

endpackage

// File: rtl/apb_uart_ctrl.sv
// APB3 slave holding UART config/status registers; pushes TX bytes and pops RX bytes with wait states.
//  state   | meaning
//  IDLE    | no transfer, waiting for a setup phase
//  ACCESS  | access phase; completes with zero waits except a valid RXDATA read
//  POP     | RX FIFO pop strobe active, waiting for registered read data
//  CAPTURE | RX byte presented on prdata, transfer completes
module apb_uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int BAUD_W     = 11,
    parameter int BAUD_RESET = 650
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [BAUD_W-1:0] baud_final_value,
    output logic [7:0]        tx_fifo_dataIn,
    output logic              tx_fifo_writeEn,
    input  logic              tx_fifo_Full,
    output logic              rx_fifo_readEn,
    input  logic              rx_fifo_Empty,
    input  logic [7:0]        rx_fifo_dataOut,
    output logic              irq
);

    state_t            state;
    act_t              act;
    act_t              dec_act;
    logic              dec_err;
    logic [DATA_W-1:0] dec_rdata;
    logic [DATA_W-1:0] prdata_q;
    logic [2:0]        ctrl;
    logic [BAUD_W-1:0] baud;
    logic              tx_ovf;
    logic              rx_udf;
    logic              done;
    logic              stat_wr;
    logic              unused_ok;

    assign unused_ok = &{1'b0, pwdata[DATA_W-1:BAUD_W], paddr[1:0]};

    always_comb begin
        dec_act   = ACT_NONE;
        dec_err   = 1'b0;
        dec_rdata = '0;
        case (paddr[4:2])
            OFF_CTRL[4:2]: begin
                if (pwrite) dec_act = ACT_WR_CTRL;
                else        dec_rdata[2:0] = ctrl;
            end
            OFF_BAUD[4:2]: begin
                if (pwrite) dec_act = ACT_WR_BAUD;
                else        dec_rdata[BAUD_W-1:0] = baud;
            end
            OFF_TX[4:2]: begin
                dec_err = !pwrite || !ctrl[CTRL_TX_EN] || tx_fifo_Full;
                if (pwrite && ctrl[CTRL_TX_EN])
                    dec_act = tx_fifo_Full ? ACT_TX_OVF : ACT_TX_PUSH;
            end
            OFF_RX[4:2]: begin
                dec_err = pwrite || rx_fifo_Empty;
                if (!pwrite)
                    dec_act = rx_fifo_Empty ? ACT_RX_UDF : ACT_RX_POP;
            end
            OFF_STAT[4:2]: begin
                if (pwrite) dec_act = ACT_WR_STAT;
                else        dec_rdata[3:0] = {rx_udf, tx_ovf, rx_fifo_Empty, tx_fifo_Full};
            end
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            act             <= ACT_NONE;
            pready          <= 1'b0;
            pslverr         <= 1'b0;
            prdata_q        <= '0;
            tx_fifo_writeEn <= 1'b0;
            tx_fifo_dataIn  <= '0;
            rx_fifo_readEn  <= 1'b0;
        end else begin
            tx_fifo_writeEn <= 1'b0;
            rx_fifo_readEn  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (psel && !penable) begin
                        state    <= S_ACCESS;
                        act      <= dec_act;
                        pready   <= (dec_act != ACT_RX_POP);
                        pslverr  <= dec_err;
                        prdata_q <= dec_rdata;
                    end
                end
                S_ACCESS: begin
                    if (psel && penable) begin
                        if (act == ACT_RX_POP) begin
                            state          <= S_POP;
                            rx_fifo_readEn <= 1'b1;
                        end else begin
                            state    <= S_IDLE;
                            pready   <= 1'b0;
                            pslverr  <= 1'b0;
                            prdata_q <= '0;
                            if (act == ACT_TX_PUSH) begin
                                tx_fifo_writeEn <= 1'b1;
                                tx_fifo_dataIn  <= pwdata[7:0];
                            end
                        end
                    end else if (!psel) begin
                        state    <= S_IDLE;
                        pready   <= 1'b0;
                        pslverr  <= 1'b0;
                        prdata_q <= '0;
                    end
                end
                S_POP: begin
                    state  <= S_CAPTURE;
                    pready <= 1'b1;
                end
                default: begin
                    state  <= S_IDLE;
                    pready <= 1'b0;
                end
            endcase
        end
    end

    // The RX FIFO's data is only valid in CAPTURE, so it bypasses the read-data register.
    assign prdata = (state == S_CAPTURE) ? {{(DATA_W-8){1'b0}}, rx_fifo_dataOut} : prdata_q;

    assign done    = (state == S_ACCESS) && psel && penable && (act != ACT_RX_POP);
    assign stat_wr = done && (act == ACT_WR_STAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl   <= '0;
            baud   <= BAUD_W'(BAUD_RESET);
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (done && act == ACT_WR_CTRL) ctrl <= pwdata[2:0];
            if (done && act == ACT_WR_BAUD) baud <= pwdata[BAUD_W-1:0];
            tx_ovf <= (done && act == ACT_TX_OVF) || (tx_ovf && !(stat_wr && pwdata[ST_TX_OVF]));
            rx_udf <= (done && act == ACT_RX_UDF) || (rx_udf && !(stat_wr && pwdata[ST_RX_UDF]));
            irq    <= (ctrl[CTRL_RX_IRQ_EN] && !rx_fifo_Empty) ||
                      (ctrl[CTRL_TX_IRQ_EN] && !tx_fifo_Full);
        end
    end

    assign baud_final_value = baud;

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Self-checking bench for apb_uart_ctrl: directed vector table, corner sequences, randomized model check.
module tb_apb_uart_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [10:0] baud_final_value;
    logic [7:0]  tx_fifo_dataIn;
    logic        tx_fifo_writeEn, tx_fifo_Full;
    logic        rx_fifo_readEn, rx_fifo_Empty;
    logic [7:0]  rx_fifo_dataOut, rx_head;
    logic        irq;

    int tests  = 0;
    int failed = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;
    logic [7:0] last_push = 8'h00;

    always #5 clk = ~clk;

    apb_uart_ctrl dut (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .baud_final_value(baud_final_value), .tx_fifo_dataIn(tx_fifo_dataIn),
        .tx_fifo_writeEn(tx_fifo_writeEn), .tx_fifo_Full(tx_fifo_Full),
        .rx_fifo_readEn(rx_fifo_readEn), .rx_fifo_Empty(rx_fifo_Empty),
        .rx_fifo_dataOut(rx_fifo_dataOut), .irq(irq)
    );

    // FIFO side: count strobes; RX FIFO returns its head byte one clock after the pop.
    always @(posedge clk) begin
        if (tx_fifo_writeEn) begin
            push_cnt++;
            last_push = tx_fifo_dataIn;
        end
        if (rx_fifo_readEn) begin
            pop_cnt++;
            rx_fifo_dataOut <= rx_head;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One APB transfer; entered and left just after a rising edge.
    task automatic apb(input bit wr, input logic [4:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int waits);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1 penable = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (pready || waits > 8) break;
            waits++;
            @(posedge clk); #1;
        end
        rd = prdata;
        err = pslverr;
        check("pready_timeout", {31'b0, (waits > 8)}, 32'd0);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] wd;
        bit          full;
        bit          empty;
        logic [7:0]  rxb;
        logic [31:0] rd;
        bit          err;
        int          waits;
        int          push;
        int          pop;
    } vec_t;

    // Reference model state, from the register map rules.
    logic [2:0]  m_ctrl;
    logic [10:0] m_baud;
    bit          m_ovf, m_udf;

    task automatic predict(input bit wr, input int sel, input logic [31:0] wd, input bit full,
                           input bit empty, input logic [7:0] rxb, output logic [31:0] rd,
                           output bit err, output int waits, output int push, output int pop);
        rd = 0; err = 0; waits = 0; push = 0; pop = 0;
        case (sel)
            0: if (wr) m_ctrl = wd[2:0]; else rd = 32'(m_ctrl);
            1: if (wr) m_baud = wd[10:0]; else rd = 32'(m_baud);
            2: begin
                if (!wr || !m_ctrl[0]) err = 1;
                else if (full) begin err = 1; m_ovf = 1; end
                else push = 1;
            end
            3: begin
                if (wr) err = 1;
                else if (empty) begin err = 1; m_udf = 1; end
                else begin pop = 1; waits = 2; rd = 32'(rxb); end
            end
            4: begin
                if (wr) begin
                    if (wd[2]) m_ovf = 0;
                    if (wd[3]) m_udf = 0;
                end else begin
                    rd = (m_udf ? 8 : 0) + (m_ovf ? 4 : 0) + (empty ? 2 : 0) + (full ? 1 : 0);
                end
            end
            default: err = 1;
        endcase
    endtask

    vec_t        vecs[$];
    logic [31:0] rd;
    logic        err;
    int          waits, p0, q0;

    initial begin
        reset = 1'b1;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        tx_fifo_Full = 0; rx_fifo_Empty = 1; rx_head = 0; rx_fifo_dataOut = 0;

        //            wr  addr   wdata          full empty rxb    rdata     err wait push pop
        vecs.push_back('{0, 5'h04, 32'h0,         0, 1, 8'h00, 32'd650,  0, 0, 0, 0});
        vecs.push_back('{0, 5'h00, 32'h0,         0, 1, 8'h00, 32'h0,    0, 0, 0, 0});
        vecs.push_back('{0, 5'h10, 32'h0,         0, 1, 8'h00, 32'h2,    0, 0, 0, 0});
        vecs.push_back('{0, 5'h10, 32'h0,         1, 0, 8'h00, 32'h1,    0, 0, 0, 0});
        vecs.push_back('{1, 5'h04, 32'h145,       0, 1, 8'h00, 32'h0,    0, 0, 0, 0});
        vecs.push_back('{0, 5'h04, 32'h0,         0, 1, 8'h00, 32'h145,  0, 0, 0, 0});
        vecs.push_back('{1, 5'h04, 32'hFFFF_F9C3, 0, 1, 8'h00, 32'h0,    0, 0, 0, 0});
        vecs.push_back('{0, 5'h04, 32'h0,         0, 1, 8'h00, 32'h1C3,  0, 0, 0, 0});
        vecs.push_back('{1, 5'h08, 32'h5A,        0, 1, 8'h00, 32'h0,    1, 0, 0, 0});
        vecs.push_back('{1, 5'h00, 32'hFFFF_FFF9, 0, 1, 8'h00, 32'h0,    0, 0, 0, 0});
        vecs.push_back('{0, 5'h00, 32'h0,         0, 1, 8'h00, 32'h1,    0, 0, 0, 0});
        vecs.push_back('{1, 5'h08, 32'hA5,        0, 1, 8'h00, 32'h0,    0, 0, 1, 0});
        vecs.push_back('{1, 5'h08, 32'h77,        1, 1, 8'h00, 32'h0,    1, 0, 0, 0});
        vecs.push_back('{0, 5'h10, 32'h0,         0, 1, 8'h00, 32'h6,    0, 0, 0, 0});
        vecs.push_back('{1, 5'h10, 32'h4,         0, 1, 8'h00, 32'h0,    0, 0, 0, 0});
        vecs.push_back('{0, 5'h10, 32'h0,         0, 1, 8'h00, 32'h2,    0, 0, 0, 0});
        vecs.push_back('{0, 5'h0C, 32'h0,         0, 0, 8'h3C, 32'h3C,   0, 2, 0, 1});
        vecs.push_back('{0, 5'h0C, 32'h0,         0, 1, 8'h55, 32'h0,    1, 0, 0, 0});
        vecs.push_back('{0, 5'h10, 32'h0,         0, 1, 8'h00, 32'hA,    0, 0, 0, 0});
        vecs.push_back('{1, 5'h10, 32'h8,         0, 1, 8'h00, 32'h0,    0, 0, 0, 0});
        vecs.push_back('{0, 5'h10, 32'h0,         0, 1, 8'h00, 32'h2,    0, 0, 0, 0});
        vecs.push_back('{1, 5'h0C, 32'h12,        0, 0, 8'h00, 32'h0,    1, 0, 0, 0});
        vecs.push_back('{0, 5'h08, 32'h0,         0, 1, 8'h00, 32'h0,    1, 0, 0, 0});
        vecs.push_back('{0, 5'h14, 32'h0,         0, 1, 8'h00, 32'h0,    1, 0, 0, 0});
        vecs.push_back('{1, 5'h1C, 32'h1,         0, 1, 8'h00, 32'h0,    1, 0, 0, 0});
        vecs.push_back('{0, 5'h03, 32'h0,         0, 1, 8'h00, 32'h1,    0, 0, 0, 0});

        repeat (3) @(posedge clk);
        #1;
        check("rst_prdata", prdata, 0);
        check("rst_pready", {31'b0, pready}, 0);
        check("rst_pslverr", {31'b0, pslverr}, 0);
        check("rst_writeEn", {31'b0, tx_fifo_writeEn}, 0);
        check("rst_readEn", {31'b0, rx_fifo_readEn}, 0);
        check("rst_dataIn", {24'b0, tx_fifo_dataIn}, 0);
        check("rst_irq", {31'b0, irq}, 0);
        check("rst_baud", {21'b0, baud_final_value}, 650);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            tx_fifo_Full = vecs[i].full;
            rx_fifo_Empty = vecs[i].empty;
            rx_head = vecs[i].rxb;
            p0 = push_cnt; q0 = pop_cnt;
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, err, waits);
            @(posedge clk); #1;
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            check($sformatf("vec%0d_pslverr", i), {31'b0, err}, {31'b0, vecs[i].err});
            check($sformatf("vec%0d_waits", i), waits, vecs[i].waits);
            check($sformatf("vec%0d_push", i), push_cnt - p0, vecs[i].push);
            check($sformatf("vec%0d_pop", i), pop_cnt - q0, vecs[i].pop);
            if (vecs[i].push != 0) check($sformatf("vec%0d_txbyte", i), {24'b0, last_push}, {24'b0, vecs[i].wd[7:0]});
        end

        // BAUD reaches the baud generator the cycle after completion.
        tx_fifo_Full = 0; rx_fifo_Empty = 1;
        apb(1, 5'h04, 32'h145, rd, err, waits);
        check("baud_next_cycle", {21'b0, baud_final_value}, 325);

        // Push strobe is high for exactly the cycle after completion.
        apb(1, 5'h08, 32'h3D, rd, err, waits);
        check("push_strobe_hi", {31'b0, tx_fifo_writeEn}, 1);
        check("push_data", {24'b0, tx_fifo_dataIn}, 32'h3D);
        @(posedge clk); #1;
        check("push_strobe_lo", {31'b0, tx_fifo_writeEn}, 0);

        // RX interrupt rises one clock after the byte arrives.
        tx_fifo_Full = 1;
        apb(1, 5'h00, 32'h3, rd, err, waits);
        repeat (2) @(posedge clk);
        #1;
        check("irq_idle", {31'b0, irq}, 0);
        rx_fifo_Empty = 0;
        #1 check("irq_same_cycle", {31'b0, irq}, 0);
        @(posedge clk); #1;
        check("irq_rise", {31'b0, irq}, 1);

        // Reset asserted while the pop strobe is active.
        rx_head = 8'h99;
        p0 = push_cnt; q0 = pop_cnt;
        psel = 1; penable = 0; pwrite = 0; paddr = 5'h0C; pwdata = 0;
        @(posedge clk); #1 penable = 1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!rx_fifo_readEn && waits < 6);
        check("pop_reached", {31'b0, rx_fifo_readEn}, 1);
        reset = 1'b1;
        #1;
        check("rst_pop_prdata", prdata, 0);
        check("rst_pop_pready", {31'b0, pready}, 0);
        check("rst_pop_pslverr", {31'b0, pslverr}, 0);
        check("rst_pop_readEn", {31'b0, rx_fifo_readEn}, 0);
        check("rst_pop_writeEn", {31'b0, tx_fifo_writeEn}, 0);
        check("rst_pop_dataIn", {24'b0, tx_fifo_dataIn}, 0);
        check("rst_pop_irq", {31'b0, irq}, 0);
        check("rst_pop_baud", {21'b0, baud_final_value}, 650);
        psel = 0; penable = 0;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_pop_no_pop", pop_cnt - q0, 0);
        check("rst_pop_no_push", push_cnt - p0, 0);
        rx_fifo_Empty = 1; tx_fifo_Full = 0;
        apb(0, 5'h00, 32'h0, rd, err, waits);
        check("rst_pop_ctrl", rd, 0);
        check("rst_pop_idle_waits", waits, 0);

        // Randomized traffic against the model, starting from reset values.
        m_ctrl = 0; m_baud = 11'd650; m_ovf = 0; m_udf = 0;
        for (int n = 0; n < 150; n++) begin
            int sel, e_waits, e_push, e_pop;
            bit wr, full, empty, e_err;
            logic [31:0] wd, e_rd;
            logic [7:0] rxb;
            sel = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) sel = 3;
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            full = 1'($urandom_range(0, 1));
            empty = 1'($urandom_range(0, 1));
            rxb = 8'($urandom);
            tx_fifo_Full = full; rx_fifo_Empty = empty; rx_head = rxb;
            predict(wr, sel, wd, full, empty, rxb, e_rd, e_err, e_waits, e_push, e_pop);
            p0 = push_cnt; q0 = pop_cnt;
            apb(wr, {3'(sel), 2'($urandom)}, wd, rd, err, waits);
            @(posedge clk); #1;
            if (!wr) check($sformatf("rnd%0d_rdata", n), rd, e_rd);
            check($sformatf("rnd%0d_pslverr", n), {31'b0, err}, {31'b0, e_err});
            check($sformatf("rnd%0d_waits", n), waits, e_waits);
            check($sformatf("rnd%0d_push", n), push_cnt - p0, e_push);
            check($sformatf("rnd%0d_pop", n), pop_cnt - q0, e_pop);
            if (e_push != 0) check($sformatf("rnd%0d_txbyte", n), {24'b0, last_push}, {24'b0, wd[7:0]});
            check($sformatf("rnd%0d_baud", n), {21'b0, baud_final_value}, {21'b0, m_baud});
            check($sformatf("rnd%0d_irq", n), {31'b0, irq},
                  {31'b0, (m_ctrl[1] & ~empty) | (m_ctrl[2] & ~full)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
